// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter/sequencer in front of the
// single-port data memory (dm).
//   clk, rstn          clock, async active-low reset
//   pN_req/wr/loadsel/addr/wdata  request fields, N = 0,1 (held until pN_gnt)
//   pN_gnt             combinational grant, transfer on edge with req & gnt
//   pN_rvalid/rdata/err  registered one-cycle completion (rdata 0 on store/err)
//   dm_wr/loadsel/byte/addr/din  dm controls, driven only during ACCESS
//   dm_dout            dm combinational read data
//   busy               high while an access is in flight (ACCESS)
module dm_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [3:0]    p0_loadsel,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [3:0]    p1_loadsel,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          dm_wr,
  output logic [3:0]    dm_loadsel,
  output logic [1:0]    dm_byte,
  output logic [AW-3:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);
  localparam int NP = 2;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic          wr;
    logic [3:0]    loadsel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t                  state;
  req_t [NP-1:0]           preq;
  req_t                    lat;
  logic [NP-1:0]           req, gnt, rvalid, err;
  logic [NP-1:0][DW-1:0]   rdata;
  logic                    owner, last_owner, mis, sel;

  assign req     = {p1_req, p0_req};
  assign preq[0] = {p0_wr, p0_loadsel, p0_addr, p0_wdata};
  assign preq[1] = {p1_wr, p1_loadsel, p1_addr, p1_wdata};

  // Byte ops never fault; halfword ops need addr[0]=0; everything else
  // (word ops and unlisted encodings) needs word alignment.
  function automatic logic misaligned(input logic [3:0] ls, input logic [1:0] lo);
    case (ls)
      4'b0001, 4'b0010, 4'b0101: return 1'b0;
      4'b0011, 4'b0100, 4'b0110: return lo[0];
      default:                   return |lo;
    endcase
  endfunction

  // Grant only from IDLE; on a tie the port that did not go last wins.
  always_comb begin
    gnt = '0;
    if (state == IDLE) begin
      if (req[0] && (!req[1] || last_owner)) gnt[0] = 1'b1;
      else if (req[1])                        gnt[1] = 1'b1;
    end
  end
  assign sel = gnt[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      lat        <= '0;
      mis        <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      rvalid     <= '0;
      rdata      <= '0;
      err        <= '0;
    end else begin
      rvalid <= '0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            lat        <= preq[sel];
            owner      <= sel;
            last_owner <= sel;
            mis        <= misaligned(preq[sel].loadsel, preq[sel].addr[1:0]);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rvalid[owner] <= 1'b1;
          rdata[owner]  <= (!lat.wr && !mis) ? dm_dout : '0;
          err[owner]    <= mis;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ACCESS);

  // dm controls are gated by the registered state, so an async reset
  // mid-access drops dm_wr immediately.
  assign dm_wr      = busy & lat.wr & ~mis;
  assign dm_loadsel = busy ? lat.loadsel       : '0;
  assign dm_byte    = busy ? lat.addr[1:0]     : '0;
  assign dm_addr    = busy ? lat.addr[AW-1:2]  : '0;
  assign dm_din     = busy ? lat.wdata         : '0;

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [3:0]  p0_loadsel, p1_loadsel;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dm_wr, busy;
  logic [3:0]  dm_loadsel;
  logic [1:0]  dm_byte;
  logic [6:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(9), .DW(32)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_loadsel(p0_loadsel), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_loadsel(p1_loadsel), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dm_wr(dm_wr), .dm_loadsel(dm_loadsel), .dm_byte(dm_byte),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
  );

  // ---------------- dm model (environment) ----------------
  logic [31:0] mem [0:127];
  logic        bd_we = 1'b0;
  logic [6:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  logic [31:0] mw;
  logic [7:0]  mb;
  logic [15:0] mh;

  always_comb begin
    mw = mem[dm_addr];
    mb = mw[8*dm_byte +: 8];
    mh = mw[16*dm_byte[1] +: 16];
    case (dm_loadsel)
      4'b0001: dm_dout = {{24{mb[7]}}, mb};
      4'b0010: dm_dout = {24'd0, mb};
      4'b0011: dm_dout = {{16{mh[15]}}, mh};
      4'b0100: dm_dout = {16'd0, mh};
      default: dm_dout = mw;
    endcase
  end

  always @(posedge clk) begin
    if (dm_wr) begin
      case (dm_loadsel)
        4'b0101: mem[dm_addr][8*dm_byte +: 8]     <= dm_din[7:0];
        4'b0110: mem[dm_addr][16*dm_byte[1] +: 16] <= dm_din[15:0];
        default: mem[dm_addr]                      <= dm_din;
      endcase
    end else if (bd_we) begin
      mem[bd_idx] <= bd_val;
    end
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_bytes [0:511];

  function automatic void ref_op(input logic w, input logic [3:0] ls, input logic [8:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic er);
    int size;
    logic [31:0] v;
    if (w) size = (ls == 4'd5) ? 1 : (ls == 4'd6) ? 2 : 4;
    else   size = (ls == 4'd1 || ls == 4'd2) ? 1 : (ls == 4'd3 || ls == 4'd4) ? 2 : 4;
    er = (int'(a) % size) != 0;
    rd = 32'd0;
    if (er) return;
    if (w) begin
      for (int k = 0; k < size; k++) ref_bytes[int'(a) + k] = wd[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = ref_bytes[int'(a) + k];
      case (ls)
        4'd1:    rd = {{24{v[7]}}, v[7:0]};
        4'd3:    rd = {{16{v[15]}}, v[15:0]};
        default: rd = v;
      endcase
    end
  endfunction

  // ---------------- driving helpers ----------------
  task automatic drive(input int p, input logic r, input logic w, input logic [3:0] ls,
                       input logic [8:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0_req = r; p0_wr = w; p0_loadsel = ls; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = r; p1_wr = w; p1_loadsel = ls; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic backdoor(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 7'(idx); bd_val = val;
    for (int k = 0; k < 4; k++) ref_bytes[4*idx + k] = val[8*k +: 8];
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One access on port p with no other traffic. Returns the completion data,
  // number of edges from transfer to rvalid (transfer edge counts as 1),
  // cycles waited for grant, and whether dm_wr was seen before completion.
  task automatic access(input int p, input logic w, input logic [3:0] ls, input logic [8:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int wt, output logic wseen, output logic ok);
    logic g, rv;
    ok = 1'b1; wt = 0; lat = 0; wseen = 1'b0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    drive(p, 1, w, ls, a, wd);
    @(negedge clk);
    g = (p == 0) ? p0_gnt : p1_gnt;
    while (!g && wt < 20) begin
      wt++;
      @(negedge clk);
      g = (p == 0) ? p0_gnt : p1_gnt;
    end
    if (!g) begin
      ok = 1'b0;
      drive(p, 0, w, ls, a, wd);
      return;
    end
    @(posedge clk); #1;
    drive(p, 0, w, ls, a, wd);
    lat = 1;
    @(negedge clk);
    wseen = dm_wr;
    rv = 1'b0;
    while (!rv && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      rv = (p == 0) ? p0_rvalid : p1_rvalid;
      if (!rv) wseen |= dm_wr;
    end
    if (!rv) begin ok = 1'b0; return; end
    rd = (p == 0) ? p0_rdata : p1_rdata;
    er = (p == 0) ? p0_err : p1_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, busy, dm_wr} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000000",
               {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, busy, dm_wr});
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata got %h %h want 0", p0_rdata, p1_rdata);
    end
    checks++;
    if ({dm_loadsel, dm_byte, dm_addr, dm_din} !== 45'd0) begin
      errors++; $display("FAIL reset_dm got %h %h %h %h want 0", dm_loadsel, dm_byte, dm_addr, dm_din);
    end
  endtask

  task automatic test_basic_load();
    logic [31:0] rd, exp; logic er, ee, ws, ok; int lat, wt;
    backdoor(4, 32'hDEADBEEF);
    access(0, 0, 4'd0, 9'h010, 32'd0, rd, er, lat, wt, ws, ok);
    ref_op(0, 4'd0, 9'h010, 32'd0, exp, ee);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout ok=%b want 1", ok); end
    checks++;
    if (wt !== 0) begin errors++; $display("FAIL basic_gnt_wait got %0d want 0", wt); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
    checks++;
    if (ws !== 1'b0) begin errors++; $display("FAIL basic_dm_wr got %b want 0", ws); end
    checks++;
    if (rd !== 32'hDEADBEEF || rd !== exp) begin
      errors++; $display("FAIL basic_rdata got %h want %h", rd, exp);
    end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", er); end
  endtask

  task automatic test_tie();
    int exp_last, grants, exp_p, p;
    logic [31:0] exp; logic ee;
    apply_reset();
    @(posedge clk); #1;
    drive(0, 1, 0, 4'd0, 9'h004, 0);
    drive(1, 1, 0, 4'd0, 9'h008, 0);
    exp_last = 1; grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (p0_gnt && p1_gnt) begin errors++; $display("FAIL tie_both_gnt cyc %0d", cyc); end
      if (p0_rvalid) begin
        ref_op(0, 4'd0, 9'h004, 0, exp, ee);
        checks++;
        if (p0_rdata !== exp) begin errors++; $display("FAIL tie_p0_rdata got %h want %h", p0_rdata, exp); end
      end
      if (p1_rvalid) begin
        ref_op(0, 4'd0, 9'h008, 0, exp, ee);
        checks++;
        if (p1_rdata !== exp) begin errors++; $display("FAIL tie_p1_rdata got %h want %h", p1_rdata, exp); end
      end
      if (p0_gnt || p1_gnt) begin
        p = p1_gnt ? 1 : 0;
        exp_p = 1 - exp_last;
        checks++;
        if (p !== exp_p) begin errors++; $display("FAIL tie_order grant %0d got p%0d want p%0d", grants, p, exp_p); end
        if (grants > 0) begin
          checks++;
          if (!(p0_rvalid || p1_rvalid)) begin
            errors++; $display("FAIL tie_gnt_in_rvalid grant %0d rvalid %b%b want a 1", grants, p1_rvalid, p0_rvalid);
          end
        end
        exp_last = exp_p;
        grants++;
        if (grants == 4) begin
          @(posedge clk); #1;
          drive(0, 0, 0, 4'd0, 9'h004, 0);
          drive(1, 0, 0, 4'd0, 9'h008, 0);
        end
      end
    end
    checks++;
    if (grants !== 4) begin errors++; $display("FAIL tie_grant_count got %0d want 4", grants); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_byte_store();
    logic [31:0] rd, exp; logic er, ee, ws, ok; int lat, wt;
    access(1, 1, 4'd5, 9'h013, 32'h12345680, rd, er, lat, wt, ws, ok);
    ref_op(1, 4'd5, 9'h013, 32'h12345680, exp, ee);
    checks++;
    if (!ok || ws !== 1'b1 || er !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL sb_store ok=%b dm_wr=%b err=%b rdata=%h want 1 1 0 0", ok, ws, er, rd);
    end
    access(1, 0, 4'd1, 9'h013, 0, rd, er, lat, wt, ws, ok);
    ref_op(0, 4'd1, 9'h013, 0, exp, ee);
    checks++;
    if (rd !== 32'hFFFFFF80 || rd !== exp) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", rd); end
    access(1, 0, 4'd2, 9'h013, 0, rd, er, lat, wt, ws, ok);
    ref_op(0, 4'd2, 9'h013, 0, exp, ee);
    checks++;
    if (rd !== 32'h00000080 || rd !== exp) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", rd); end
    access(1, 0, 4'd0, 9'h010, 0, rd, er, lat, wt, ws, ok);
    ref_op(0, 4'd0, 9'h010, 0, exp, ee);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL sb_neighbours got %h want %h", rd, exp); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, exp; logic er, ee, ws, ok; int lat, wt;
    access(0, 1, 4'd6, 9'h021, 32'h00001234, rd, er, lat, wt, ws, ok);
    ref_op(1, 4'd6, 9'h021, 32'h00001234, exp, ee);
    checks++;
    if (!ok || wt !== 0 || lat !== 2) begin
      errors++; $display("FAIL mis_handshake ok=%b wait=%0d lat=%0d want 1 0 2", ok, wt, lat);
    end
    checks++;
    if (ws !== 1'b0) begin errors++; $display("FAIL mis_dm_wr got %b want 0", ws); end
    checks++;
    if (er !== 1'b1 || er !== ee || rd !== 32'd0) begin
      errors++; $display("FAIL mis_resp err=%b rdata=%h want 1 0", er, rd);
    end
    access(0, 0, 4'd0, 9'h020, 0, rd, er, lat, wt, ws, ok);
    ref_op(0, 4'd0, 9'h020, 0, exp, ee);
    checks++;
    if (rd !== exp || er !== 1'b0) begin errors++; $display("FAIL mis_no_write got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] old_w, rd; logic ee;
    ref_op(0, 4'd0, 9'h040, 0, old_w, ee);
    @(posedge clk); #1;
    drive(0, 1, 1, 4'd7, 9'h040, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt got %b want 1", p0_gnt); end
    @(posedge clk); #1;
    drive(0, 0, 1, 4'd7, 9'h040, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (dm_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_wr got %b want 1", dm_wr); end
    rstn = 1'b0;
    #1;
    checks++;
    if (dm_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop dm_wr=%b busy=%b want 0 0", dm_wr, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid got %b want 0", p0_rvalid); end
    @(posedge clk); #1;
    rstn = 1'b1;
    // either the old or the new word is acceptable; sync the reference to dm
    for (int k = 0; k < 4; k++) ref_bytes[9'h040 + k] = mem[16][8*k +: 8];
    @(posedge clk); #1;
    drive(0, 1, 0, 4'd0, 9'h040, 0);
    drive(1, 1, 0, 4'd0, 9'h044, 0);
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_mid_tie got p0=%b p1=%b want 1 0", p0_gnt, p1_gnt);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 4'd0, 9'h040, 0);
    drive(1, 0, 0, 4'd0, 9'h044, 0);
    @(negedge clk);
    @(negedge clk);
    rd = p0_rdata;
    checks++;
    if (p0_rvalid !== 1'b1 || (rd !== old_w && rd !== 32'hCAFEF00D)) begin
      errors++; $display("FAIL rst_mid_after rvalid=%b rdata=%h want 1 %h|cafef00d", p0_rvalid, rd, old_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp; logic ee;
    @(posedge clk); #1;
    drive(0, 1, 0, 4'd0, 9'h030, 0);
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_p0_gnt got %b want 1", p0_gnt); end
    @(posedge clk); #1;
    drive(0, 0, 0, 4'd0, 9'h030, 0);
    drive(1, 1, 0, 4'd4, 9'h036, 0);
    @(negedge clk);
    checks++;
    if (p1_gnt !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_access p1_gnt=%b busy=%b want 0 1", p1_gnt, busy);
    end
    @(negedge clk);
    ref_op(0, 4'd0, 9'h030, 0, exp, ee);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== exp || p1_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_rvalid_cycle rv=%b rdata=%h p1_gnt=%b want 1 %h 1", p0_rvalid, p0_rdata, p1_gnt, exp);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 4'd4, 9'h036, 0);
    @(negedge clk);
    checks++;
    if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_p1_early got %b want 0", p1_rvalid); end
    @(negedge clk);
    ref_op(0, 4'd4, 9'h036, 0, exp, ee);
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== exp) begin
      errors++; $display("FAIL b2b_p1_resp rv=%b rdata=%h want 1 %h", p1_rvalid, p1_rdata, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, wd; logic er, ee, ws, ok, w; logic [3:0] ls; logic [8:0] a;
    int lat, wt, p, size;
    for (int n = 0; n < 200; n++) begin
      p  = $urandom_range(0, 1);
      w  = 1'($urandom_range(0, 1));
      ls = w ? 4'($urandom_range(5, 7)) : 4'($urandom_range(0, 4));
      a  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
      wd = $urandom;
      size = (ls == 4'd1 || ls == 4'd2 || ls == 4'd5) ? 1 :
             (ls == 4'd3 || ls == 4'd4 || ls == 4'd6) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = 9'(int'(a) - (int'(a) % size));
      access(p, w, ls, a, wd, rd, er, lat, wt, ws, ok);
      ref_op(w, ls, a, wd, exp, ee);
      checks++;
      if (!ok || lat !== 2 || wt !== 0 || rd !== exp || er !== ee || ws !== (w & ~ee)) begin
        errors++;
        $display("FAIL rand_%0d p%0d wr=%b ls=%h a=%h: ok=%b lat=%0d wait=%0d rdata=%h err=%b dm_wr=%b want 1 2 0 %h %b %b",
                 n, p, w, ls, a, ok, lat, wt, rd, er, ws, exp, ee, w & ~ee);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    logic [31:0] v;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      backdoor(i, v);
    end
    apply_reset();
    test_reset();
    test_basic_load();
    test_tie();
    test_byte_store();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end
endmodule
